fetch_predict_stage: RTL
========================

# fetch_predict_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, drives the instruction ROM address, predicts conditional branches with a 2-bit saturating branch history table (BHT), and registers the fetched instruction into the IF/ID pipeline register consumed by decode and the ID/EX register. It resolves redirects from ID (jumps) and EX (branch mispredicts), and trains the BHT from EX branch outcomes.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `BHT_BITS`, 6, log2 of BHT entries; index = PC[BHT_BITS+1:2]

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard stall from ID; hold PC and IF/ID
- `instrData`  in  32  instruction ROM read data for `instrAddr` (combinational ROM)
- `jumpID`  in  1  jump decoded in ID this cycle
- `jumpTargetID`  in  32  jump destination
- `resolveValid`  in  1  conditional branch resolved in EX this cycle
- `resolvePC`  in  32  PC of resolving branch
- `resolveTaken`  in  1  actual outcome
- `resolvePrediction`  in  1  prediction carried with that branch (predictionIDEX)
- `resolveTarget`  in  32  computed taken target
- `instrAddr`  out  32  current PC to ROM
- `pcPlus4IFID`  out  32  PC+4 of instruction in IF/ID
- `instructionROMOutIFID`  out  32  instruction in IF/ID
- `predictionIFID`  out  1  predicted-taken flag for that instruction
- `validIFID`  out  1  IF/ID holds a real instruction
- `mispredict`  out  1  combinational; flush request to ID/EX

## Operation
- Predecode: `instrData[31:26]` in {6'h04,6'h05,6'h06,6'h07} = branch. Target = PC+4 + {{14{imm[15]}}, imm, 2'b00}, 32-bit wrap.
- Prediction = branch AND BHT[PC index][1].
- `mispredict` = resolveValid AND (resolveTaken != resolvePrediction). Correct PC = resolveTaken ? resolveTarget : resolvePC+4.
- Next PC priority: (1) mispredict → correct PC; (2) stall → hold PC; (3) jumpID → jumpTargetID; (4) predicted taken → branch target; (5) PC+4.
- IF/ID update priority: (1) mispredict → bubble; (2) stall → hold; (3) jumpID → bubble; (4) load {PC+4, instrData, prediction, 1}.
- Bubble = all IF/ID outputs zero (pcPlus4IFID, instruction, prediction, valid).
- Mispredict overrides stall (EX instruction is older). Stall overrides jumpID (ID instruction re-decodes next cycle).
- BHT training on resolveValid, independent of stall/flush: counter at resolvePC index increments if taken (saturate 2'b11), else decrements (saturate 2'b00).
- No branch delay slot; wrong-path instruction always squashed.

## Timing
- Reset (asynchronous assert, synchronous-safe release): PC=RESET_PC, IF/ID bubble (all outputs 0), every BHT entry = 2'b01 (weakly not taken). `instrAddr`=RESET_PC immediately.
- Fetch latency 1: instruction at PC in cycle n appears on IF/ID outputs in cycle n+1.
- Predicted-taken branch: target fetched in n+1, zero bubbles.
- Jump in ID: one bubble. Mispredict in EX: IF/ID bubble this edge; downstream flushes ID/EX from `mispredict`; correct path fetched n+1.
- BHT read-during-write same index: prediction uses pre-update value; new value visible next cycle.
- `mispredict` is 0 whenever resolveValid=0, including during reset.
- Reset mid-stall or mid-redirect: all pending redirects discarded; fetch restarts at RESET_PC.

## Test plan
- Reset release, ROM returns 32'h2002_0005 at 0 → instrAddr 0,4,8…; IF/ID at cycle 1 = {pcPlus4 4, instr 32'h2002_0005, pred 0, valid 1}.
- beq at PC 0x10, imm 16'h0004, BHT 01 → not predicted, next PC 0x14; train taken twice → counter 11; refetch 0x10 → next PC 0x24, predictionIFID 1.
- Stall held 3 cycles with PC 0x20 → instrAddr stays 0x20, IF/ID unchanged; jumpID asserted same cycles ignored until stall drops.
- jumpID target 0x100 while fetching 0x40 → IF/ID bubble next cycle, instrAddr 0x100.
- resolveValid, resolvePC 0x30, taken 0, prediction 1, simultaneous stall and jumpID → mispredict 1, next PC 0x34, IF/ID bubble, counter decremented.
- Counter saturation: 4 not-taken resolves from 01 → 00 remains 00; negative imm 16'hFFFF at PC 0x8 predicted → target 0x8.

Source files
------------

// File: rtl/fetch_predict_stage.sv
// Instruction-fetch stage: PC ownership, branch predecode, 2-bit BHT prediction
// and the IF/ID pipeline register, with ID jump and EX mispredict redirects.
module fetch_predict_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned BHT_BITS = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instrData,
    input  logic        jumpID,
    input  logic [31:0] jumpTargetID,
    input  logic        resolveValid,
    input  logic [31:0] resolvePC,
    input  logic        resolveTaken,
    input  logic        resolvePrediction,
    input  logic [31:0] resolveTarget,
    output logic [31:0] instrAddr,
    output logic [31:0] pcPlus4IFID,
    output logic [31:0] instructionROMOutIFID,
    output logic        predictionIFID,
    output logic        validIFID,
    output logic        mispredict
);

    localparam int unsigned XLEN        = 32;
    localparam int unsigned BHT_ENTRIES = 1 << BHT_BITS;
    localparam logic [1:0]  CTR_WEAK_NT = 2'b01;
    localparam logic [1:0]  CTR_MAX     = 2'b11;
    localparam logic [1:0]  CTR_MIN     = 2'b00;

    typedef struct packed {
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            prediction;
        logic            valid;
    } ifid_t;

    logic [XLEN-1:0]     pc_q;
    logic [XLEN-1:0]     pc_d;
    logic [XLEN-1:0]     pc_plus4;
    logic [XLEN-1:0]     branch_offset;
    logic [XLEN-1:0]     branch_target;
    logic [XLEN-1:0]     correct_pc;
    logic [5:0]          opcode;
    logic                is_branch;
    logic                predict_taken;
    logic [BHT_BITS-1:0] fetch_idx;
    logic [BHT_BITS-1:0] resolve_idx;
    logic [1:0]          fetch_ctr;
    logic [1:0]          resolve_ctr;
    logic [1:0]          resolve_ctr_next;
    logic [1:0]          bht_q [BHT_ENTRIES];
    ifid_t               ifid_q;
    ifid_t               ifid_d;

    // Predecode: beq/bne/blez/bgtz occupy opcodes 4..7
    always_comb begin
        opcode        = instrData[31:26];
        is_branch     = (opcode[5:2] == 4'b0001);
        pc_plus4      = pc_q + XLEN'(4);
        branch_offset = {{14{instrData[15]}}, instrData[15:0], 2'b00};
        branch_target = pc_plus4 + branch_offset;
        fetch_idx     = pc_q[BHT_BITS+1:2];
        fetch_ctr     = bht_q[fetch_idx];
        predict_taken = is_branch & fetch_ctr[1];
    end

    // EX resolution: flush request and architecturally correct PC
    assign mispredict = resolveValid & (resolveTaken ^ resolvePrediction);
    assign correct_pc = resolveTaken ? resolveTarget : (resolvePC + XLEN'(4));

    // Next PC / IF/ID selection; an older mispredict beats stall, stall beats jump
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (mispredict) begin
            pc_d   = correct_pc;
            ifid_d = '0;
        end else if (!stall) begin
            if (jumpID) begin
                pc_d   = jumpTargetID;
                ifid_d = '0;
            end else begin
                pc_d              = predict_taken ? branch_target : pc_plus4;
                ifid_d.pc_plus4   = pc_plus4;
                ifid_d.instr      = instrData;
                ifid_d.prediction = predict_taken;
                ifid_d.valid      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            ifid_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    // Saturating counter update for the resolving branch
    always_comb begin
        resolve_idx = resolvePC[BHT_BITS+1:2];
        resolve_ctr = bht_q[resolve_idx];
        if (resolveTaken) begin
            resolve_ctr_next = (resolve_ctr == CTR_MAX) ? CTR_MAX : resolve_ctr + 2'd1;
        end else begin
            resolve_ctr_next = (resolve_ctr == CTR_MIN) ? CTR_MIN : resolve_ctr - 2'd1;
        end
    end

    // Training ignores stall/flush; fetch reads the pre-update value this cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[BHT_BITS'(i)] <= CTR_WEAK_NT;
            end
        end else if (resolveValid) begin
            bht_q[resolve_idx] <= resolve_ctr_next;
        end
    end

    assign instrAddr             = pc_q;
    assign pcPlus4IFID           = ifid_q.pc_plus4;
    assign instructionROMOutIFID = ifid_q.instr;
    assign predictionIFID        = ifid_q.prediction;
    assign validIFID             = ifid_q.valid;

endmodule
